// File: rtl/tmr_scrub_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tmr_scrub_ctrl
//
// Scrub scheduler for a bank of DIV TMR register groups. A sweep visits the
// groups in order, one per cycle. Each visit pulses that group's refresh
// enable so the voted value is rewritten into all three copies. A sweep
// starts on the periodic timer, on force_sweep, or immediately when any
// voter reports a mismatch. Functional writes always win over a refresh. A
// group that stays blocked too long is skipped. Refreshes that correct a
// mismatch are counted in a saturating counter.
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          asynchronous reset, active-high
//   en           scrubber enable; dropping it aborts a sweep
//   force_sweep  start a sweep now (dropped while busy)
//   mismatch     per-group voter disagreement flag
//   func_we      per-group functional write this cycle
//   clr_cnt      synchronous clear of err_cnt / err_sat
//   scrub_en     per-group refresh enable, at most one bit high
//   grp_idx      group currently visited
//   busy         sweep in progress (state SWEEP)
//   sweep_done   one-cycle pulse after a completed sweep (state FINISH)
//   skipped      sticky: a group was skipped in the last sweep
//   err_cnt      corrected mismatches, saturating
//   err_sat      sticky: err_cnt reached all-ones
//
// FSM state is observable: busy is high exactly in SWEEP and sweep_done is
// high exactly in FINISH, so IDLE is the case where both are low.
//
// Arbitration between refresh and functional write: a refresh of group g is
// issued in a cycle only when func_we[g] is low. A blocked visit holds the
// group and retries on the next cycle. The issue decision and its effects
// (advance, error count) happen in the same cycle as the visible scrub_en.
// -----------------------------------------------------------------------------
module tmr_scrub_ctrl #(
    parameter int DIV       = 16,
    parameter int PERIOD    = 256,
    parameter int STALL_MAX = 8,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    force_sweep,
    input  logic [DIV-1:0]          mismatch,
    input  logic [DIV-1:0]          func_we,
    input  logic                    clr_cnt,
    output logic [DIV-1:0]          scrub_en,
    output logic [$clog2(DIV)-1:0]  grp_idx,
    output logic                    busy,
    output logic                    sweep_done,
    output logic                    skipped,
    output logic [CNT_W-1:0]        err_cnt,
    output logic                    err_sat
);

    localparam int IDX_W   = $clog2(DIV);
    localparam int TMR_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int STALL_W = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic [STALL_W-1:0] stall, stall_nxt;
    logic [IDX_W-1:0]   grp_nxt;
    logic               skipped_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               sat_nxt;

    logic [DIV-1:0]     visit_onehot;
    logic               issue;
    logic               advance;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            stall   <= '0;
            grp_idx <= '0;
            skipped <= 1'b0;
            err_cnt <= '0;
            err_sat <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            stall   <= stall_nxt;
            grp_idx <= grp_nxt;
            skipped <= skipped_nxt;
            err_cnt <= cnt_nxt;
            err_sat <= sat_nxt;
        end
    end

    // Next-state and outputs
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        stall_nxt   = stall;
        grp_nxt     = grp_idx;
        skipped_nxt = skipped;
        cnt_nxt     = err_cnt;
        sat_nxt     = err_sat;
        scrub_en    = '0;
        busy        = 1'b0;
        sweep_done  = 1'b0;
        issue       = 1'b0;
        advance     = 1'b0;

        visit_onehot          = '0;
        visit_onehot[grp_idx] = 1'b1;

        case (state)
            IDLE: begin
                // The timer only runs while enabled; with en low it holds.
                if (en) begin
                    if (force_sweep || (|mismatch) ||
                        (timer == TMR_W'(PERIOD - 1))) begin
                        state_nxt   = SWEEP;
                        timer_nxt   = '0;
                        grp_nxt     = '0;
                        stall_nxt   = '0;
                        skipped_nxt = 1'b0;
                    end else begin
                        timer_nxt = timer + TMR_W'(1);
                    end
                end
            end

            SWEEP: begin
                busy = 1'b1;
                if (!en) begin
                    // Abort: no refresh in this cycle, no FINISH pulse.
                    state_nxt = IDLE;
                    timer_nxt = '0;
                    grp_nxt   = '0;
                    stall_nxt = '0;
                end else begin
                    scrub_en = visit_onehot & ~func_we;
                    if (!func_we[grp_idx]) begin
                        issue   = 1'b1;
                        advance = 1'b1;
                    end else if (stall == STALL_W'(STALL_MAX - 1)) begin
                        // Blocked for STALL_MAX cycles in a row: give up on it.
                        skipped_nxt = 1'b1;
                        advance     = 1'b1;
                    end else begin
                        stall_nxt = stall + STALL_W'(1);
                    end

                    if (advance) begin
                        stall_nxt = '0;
                        if (grp_idx == IDX_W'(DIV - 1)) begin
                            state_nxt = FINISH;
                            grp_nxt   = '0;
                        end else begin
                            grp_nxt = grp_idx + IDX_W'(1);
                        end
                    end
                end
            end

            FINISH: begin
                sweep_done = 1'b1;
                state_nxt  = IDLE;
                timer_nxt  = '0;
            end

            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
                grp_nxt   = '0;
                stall_nxt = '0;
            end
        endcase

        // Only a refresh that actually went out corrects the upset.
        if (issue && mismatch[grp_idx] && !(&err_cnt)) begin
            cnt_nxt = err_cnt + CNT_W'(1);
            if (&cnt_nxt) begin
                sat_nxt = 1'b1;
            end
        end

        // Clear has priority over a same-cycle increment.
        if (clr_cnt) begin
            cnt_nxt = '0;
            sat_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
`timescale 1ns/1ps
module tb_tmr_scrub_ctrl;

  localparam int DIV       = 4;
  localparam int PERIOD    = 8;
  localparam int STALL_MAX = 3;
  localparam int CNT_W     = 4;

  // Per-cycle stimulus applied during a sweep
  typedef struct packed {
    logic [3:0] fwe;
    logic [3:0] mm;
    logic       fs;
    logic       clr;
  } stim_t;

  logic             clk;
  logic             rst;
  logic             en;
  logic             force_sweep;
  logic [DIV-1:0]   mismatch;
  logic [DIV-1:0]   func_we;
  logic             clr_cnt;
  logic [DIV-1:0]   scrub_en;
  logic [1:0]       grp_idx;
  logic             busy;
  logic             sweep_done;
  logic             skipped;
  logic [CNT_W-1:0] err_cnt;
  logic             err_sat;

  int errors = 0;
  int checks = 0;

  // Expected {busy, sweep_done, scrub_en, err_cnt} per sweep cycle
  logic [9:0] exp_q[$];
  stim_t      stim_q[$];

  tmr_scrub_ctrl #(
    .DIV(DIV), .PERIOD(PERIOD), .STALL_MAX(STALL_MAX), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .force_sweep(force_sweep),
    .mismatch(mismatch), .func_we(func_we), .clr_cnt(clr_cnt),
    .scrub_en(scrub_en), .grp_idx(grp_idx), .busy(busy),
    .sweep_done(sweep_done), .skipped(skipped), .err_cnt(err_cnt),
    .err_sat(err_sat)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- driver / scoreboard tasks ----------------
  task automatic push_cycle(input logic [3:0] sen, input logic [3:0] cnt,
                            input logic [3:0] fwe, input logic [3:0] mm,
                            input logic fs, input logic clr);
    stim_t s;
    s.fwe = fwe; s.mm = mm; s.fs = fs; s.clr = clr;
    stim_q.push_back(s);
    exp_q.push_back({2'b10, sen, cnt});
  endtask

  // Apply one stimulus entry per cycle and pop/compare one expectation.
  task automatic check_cycles(input string name);
    stim_t      s;
    logic [9:0] e;
    logic [9:0] got;
    int         c = 0;
    while (exp_q.size() > 0) begin
      if (stim_q.size() > 0) s = stim_q.pop_front();
      else s = '0;
      func_we = s.fwe; mismatch = s.mm; force_sweep = s.fs; clr_cnt = s.clr;
      #1;
      e   = exp_q.pop_front();
      got = {busy, sweep_done, scrub_en, err_cnt};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: busy/done/scrub_en/err_cnt got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 name, c, got[9], got[8], got[7:4], got[3:0], e[9], e[8], e[7:4], e[3:0]);
      end
      @(negedge clk);
      c++;
    end
  endtask

  // Sweep cycles, then the FINISH pulse; returns at the first IDLE negedge.
  task automatic run_sweep(input string name);
    check_cycles(name);
    func_we = '0; mismatch = '0; force_sweep = 1'b0; clr_cnt = 1'b0;
    #1;
    checks++;
    if ({busy, sweep_done} !== 2'b01) begin
      errors++;
      $display("FAIL %s finish: busy/sweep_done got %b/%b want 0/1", name, busy, sweep_done);
    end
    @(negedge clk);
  endtask

  // Count idle cycles until busy rises (bounded).
  task automatic wait_busy(input string name, input int exp_n);
    int n = 0;
    #1;
    while (busy !== 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (n !== exp_n) begin
      errors++;
      $display("FAIL %s: sweep started after %0d idle cycles, want %0d", name, n, exp_n);
    end
  endtask

  task automatic plain_sweep(input logic [3:0] cnt);
    push_cycle(4'b0001, cnt, 4'b0, 4'b0, 1'b0, 1'b0);
    push_cycle(4'b0010, cnt, 4'b0, 4'b0, 1'b0, 1'b0);
    push_cycle(4'b0100, cnt, 4'b0, 4'b0, 1'b0, 1'b0);
    push_cycle(4'b1000, cnt, 4'b0, 4'b0, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; en = 1'b0; force_sweep = 1'b0; mismatch = '0;
    func_we = '0; clr_cnt = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({scrub_en, grp_idx, busy, sweep_done, skipped, err_cnt, err_sat} !== '0) begin
      errors++;
      $display("FAIL reset outputs: scrub_en=%b grp_idx=%0d busy=%b done=%b skipped=%b err_cnt=%0d err_sat=%b, want all 0",
               scrub_en, grp_idx, busy, sweep_done, skipped, err_cnt, err_sat);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_periodic();
    en = 1'b1;
    wait_busy("periodic first start", 8);
    plain_sweep(4'd0);
    run_sweep("periodic sweep 1");
    wait_busy("periodic restart", 8);
    plain_sweep(4'd0);
    run_sweep("periodic sweep 2");
  endtask

  task automatic test_mismatch();
    mismatch = 4'b0100;
    @(negedge clk);
    push_cycle(4'b0001, 4'd0, 4'b0, 4'b0100, 1'b0, 1'b0);
    push_cycle(4'b0010, 4'd0, 4'b0, 4'b0100, 1'b0, 1'b0);
    push_cycle(4'b0100, 4'd0, 4'b0, 4'b0100, 1'b0, 1'b0);
    push_cycle(4'b1000, 4'd1, 4'b0, 4'b0100, 1'b0, 1'b0);
    run_sweep("mismatch sweep");
    // Still reported after FINISH: starts again straight from IDLE.
    mismatch = 4'b0100;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mismatch idle gap: busy got %b want 0", busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mismatch retrigger: busy got %b want 1", busy);
    end
    // Mismatch on already-visited group 0 arrives mid-sweep: no restart.
    push_cycle(4'b0001, 4'd1, 4'b0, 4'b0000, 1'b0, 1'b0);
    push_cycle(4'b0010, 4'd1, 4'b0, 4'b0000, 1'b0, 1'b0);
    push_cycle(4'b0100, 4'd1, 4'b0, 4'b0001, 1'b0, 1'b0);
    push_cycle(4'b1000, 4'd1, 4'b0, 4'b0001, 1'b0, 1'b0);
    run_sweep("late mismatch sweep");
    mismatch = 4'b0001;
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL late mismatch retrigger: busy got %b want 1", busy);
    end
    push_cycle(4'b0001, 4'd1, 4'b0, 4'b0001, 1'b0, 1'b0);
    push_cycle(4'b0010, 4'd2, 4'b0, 4'b0000, 1'b0, 1'b0);
    push_cycle(4'b0100, 4'd2, 4'b0, 4'b0000, 1'b0, 1'b0);
    push_cycle(4'b1000, 4'd2, 4'b0, 4'b0000, 1'b0, 1'b0);
    run_sweep("group0 correction sweep");
  endtask

  task automatic test_write_priority();
    force_sweep = 1'b1;
    @(negedge clk);
    push_cycle(4'b0001, 4'd2, 4'b0000, 4'b0, 1'b0, 1'b0);
    push_cycle(4'b0000, 4'd2, 4'b0010, 4'b0, 1'b0, 1'b0);
    push_cycle(4'b0000, 4'd2, 4'b0010, 4'b0, 1'b0, 1'b0);
    push_cycle(4'b0010, 4'd2, 4'b0000, 4'b0, 1'b0, 1'b0);
    push_cycle(4'b0100, 4'd2, 4'b0000, 4'b0, 1'b0, 1'b0);
    push_cycle(4'b1000, 4'd2, 4'b0000, 4'b0, 1'b0, 1'b0);
    run_sweep("write priority");
    checks++;
    if (skipped !== 1'b0) begin
      errors++;
      $display("FAIL write priority skipped: got %b want 0", skipped);
    end
  endtask

  task automatic test_skip();
    force_sweep = 1'b1;
    @(negedge clk);
    push_cycle(4'b0001, 4'd2, 4'b0010, 4'b0, 1'b0, 1'b0);
    push_cycle(4'b0000, 4'd2, 4'b0010, 4'b0, 1'b0, 1'b0);
    push_cycle(4'b0000, 4'd2, 4'b0010, 4'b0, 1'b0, 1'b0);
    push_cycle(4'b0000, 4'd2, 4'b0010, 4'b0, 1'b0, 1'b0);
    push_cycle(4'b0100, 4'd2, 4'b0010, 4'b0, 1'b1, 1'b0); // force while busy
    push_cycle(4'b1000, 4'd2, 4'b0010, 4'b0, 1'b0, 1'b0);
    run_sweep("skip");
    checks++;
    if (skipped !== 1'b1) begin
      errors++;
      $display("FAIL skip sticky: skipped got %b want 1", skipped);
    end
    // The force seen while busy is not queued: next start is periodic.
    wait_busy("force dropped while busy", 8);
    plain_sweep(4'd2);
    run_sweep("after skip sweep");
    checks++;
    if (skipped !== 1'b0) begin
      errors++;
      $display("FAIL skipped cleared: got %b want 0", skipped);
    end
  endtask

  task automatic test_saturation();
    int model = 0;
    clr_cnt = 1'b1;
    mismatch = 4'b1111;
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      if (s > 0) begin
        mismatch = 4'b1111;
        @(negedge clk);
      end
      for (int g = 0; g < 4; g++) begin
        logic [3:0] sen;
        sen = 4'b0001 << g;
        push_cycle(sen, 4'(model), 4'b0, 4'b1111, 1'b0, 1'b0);
        if (model < 15) model++;
      end
      run_sweep("saturation sweep");
    end
    checks++;
    if ({err_cnt, err_sat} !== {4'd15, 1'b1}) begin
      errors++;
      $display("FAIL saturation: err_cnt/err_sat got %0d/%b want 15/1", err_cnt, err_sat);
    end
  endtask

  task automatic test_clear();
    force_sweep = 1'b1;
    @(negedge clk);
    push_cycle(4'b0001, 4'd15, 4'b0, 4'b0011, 1'b0, 1'b1);
    push_cycle(4'b0010, 4'd0,  4'b0, 4'b0011, 1'b0, 1'b1); // increment + clear
    push_cycle(4'b0100, 4'd0,  4'b0, 4'b0000, 1'b0, 1'b0);
    push_cycle(4'b1000, 4'd0,  4'b0, 4'b0000, 1'b0, 1'b0);
    run_sweep("clear");
    checks++;
    if (err_sat !== 1'b0) begin
      errors++;
      $display("FAIL clear err_sat: got %b want 0", err_sat);
    end
  endtask

  task automatic test_abort();
    force_sweep = 1'b1;
    @(negedge clk);
    push_cycle(4'b0001, 4'd0, 4'b0, 4'b0, 1'b0, 1'b0);
    push_cycle(4'b0010, 4'd0, 4'b0, 4'b0, 1'b0, 1'b0);
    check_cycles("abort lead-in");
    en = 1'b0; // now visiting group 2
    @(negedge clk);
    #1;
    checks++;
    if ({busy, sweep_done, scrub_en} !== 6'b0) begin
      errors++;
      $display("FAIL abort idle: busy/done/scrub_en got %b/%b/%b want 0/0/0000",
               busy, sweep_done, scrub_en);
    end
    @(negedge clk);
    #1;
    checks++;
    if (sweep_done !== 1'b0) begin
      errors++;
      $display("FAIL abort no done: sweep_done got %b want 0", sweep_done);
    end
    en = 1'b1;
    wait_busy("restart after abort", 8);
    plain_sweep(4'd0);
    run_sweep("post-abort sweep");
  endtask

  task automatic test_reset_mid();
    force_sweep = 1'b1;
    @(negedge clk);
    push_cycle(4'b0001, 4'd0, 4'b0, 4'b0001, 1'b0, 1'b0);
    check_cycles("reset lead-in");
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({scrub_en, grp_idx, busy, sweep_done, skipped, err_cnt, err_sat} !== '0) begin
      errors++;
      $display("FAIL reset mid-sweep: scrub_en=%b grp_idx=%0d busy=%b done=%b skipped=%b err_cnt=%0d err_sat=%b, want all 0",
               scrub_en, grp_idx, busy, sweep_done, skipped, err_cnt, err_sat);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_periodic();
    test_mismatch();
    test_write_priority();
    test_skip();
    test_saturation();
    test_clear();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
